// File: rtl/iprf_wb_arb_if.sv
// Shared packet types and the writeback request/PRF-write bundle between
// the execution-side requesters, the writeback arbiter and the PRF.
package iprf_wb_pkg;
  localparam int IPRF_NUM_WRITES = 2;
  localparam int PDST_W          = 7;
  localparam int DATA_W          = 32;

  typedef struct packed {
    logic [PDST_W-1:0] pdst;
    logic [DATA_W-1:0] data;
  } t_prf_wr_pkt;

  typedef struct packed {
    logic       valid;
    logic [5:0] rob_id;
  } t_nuke_pkt;
endpackage

interface iprf_wb_arb_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = iprf_wb_pkg::IPRF_NUM_WRITES
);
  logic [NUM_REQ-1:0]                            req_valid_ex;
  iprf_wb_pkg::t_prf_wr_pkt [NUM_REQ-1:0]        req_pkt_ex;
  logic [NUM_REQ-1:0]                            req_ready_ex;
  logic [NUM_PORTS-1:0]                          iprf_wr_en_ro0;
  iprf_wb_pkg::t_prf_wr_pkt [NUM_PORTS-1:0]      iprf_wr_pkt_ro0;

  modport master (
    output req_valid_ex, req_pkt_ex,
    input  req_ready_ex, iprf_wr_en_ro0, iprf_wr_pkt_ro0
  );

  modport slave (
    input  req_valid_ex, req_pkt_ex,
    output req_ready_ex, iprf_wr_en_ro0, iprf_wr_pkt_ro0
  );
endinterface

// File: rtl/iprf_wb_arb.sv
// Writeback arbiter: one holding buffer per requester, round-robin grant of up
// to NUM_PORTS buffered writes per cycle onto registered PRF write ports.
module iprf_wb_arb
  import iprf_wb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = IPRF_NUM_WRITES,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          reset,
  input  t_nuke_pkt     nuke_rb1,
  iprf_wb_arb_if.slave  bus,
  output logic          wb_busy
);

  logic [NUM_REQ-1:0]              hold_vld_q, hold_vld_d;
  t_prf_wr_pkt [NUM_REQ-1:0]       hold_pkt_q, hold_pkt_d;
  logic [REQ_IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]            wr_en_q, wr_en_d;
  t_prf_wr_pkt [NUM_PORTS-1:0]     wr_pkt_q, wr_pkt_d;
  logic [NUM_REQ-1:0]              grant, ready, accept;
  logic                            nuke;
  int                              scan_idx, gcnt;
  logic [REQ_IDX_W-1:0]            sidx;
  logic                            unused_nuke_fields;

  assign nuke               = nuke_rb1.valid;
  assign unused_nuke_fields = ^nuke_rb1.rob_id;

  // Grant scan: walk from rr_ptr, first NUM_PORTS valid holders fill ports in order
  always_comb begin
    grant    = '0;
    wr_en_d  = '0;
    wr_pkt_d = '0;
    rr_ptr_d = rr_ptr_q;
    gcnt     = 0;
    scan_idx = 0;
    sidx     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      scan_idx = (int'(rr_ptr_q) + j) % NUM_REQ;
      sidx     = REQ_IDX_W'(scan_idx);
      if (!nuke && hold_vld_q[sidx] && gcnt < NUM_PORTS) begin
        grant[sidx] = 1'b1;
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (k == gcnt) begin
            wr_en_d[k]  = 1'b1;
            wr_pkt_d[k] = hold_pkt_q[sidx];
          end
        end
        rr_ptr_d = REQ_IDX_W'((scan_idx + 1) % NUM_REQ);
        gcnt     = gcnt + 1;
      end
    end
  end

  // A buffer being drained this cycle can take a new packet at the same edge
  always_comb begin
    ready      = '0;
    accept     = '0;
    hold_vld_d = hold_vld_q;
    hold_pkt_d = hold_pkt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i]  = ~nuke & (~hold_vld_q[i] | grant[i]);
      accept[i] = bus.req_valid_ex[i] & ready[i];
      if (nuke) begin
        hold_vld_d[i] = 1'b0;
      end else if (accept[i]) begin
        hold_vld_d[i] = 1'b1;
        hold_pkt_d[i] = bus.req_pkt_ex[i];
      end else if (grant[i]) begin
        hold_vld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_vld_q <= '0;
      rr_ptr_q   <= '0;
      wr_en_q    <= '0;
      wr_pkt_q   <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_pkt_q   <= wr_pkt_d;
    end
  end

  // Buffered payload is qualified by hold_vld_q, so it needs no reset
  always_ff @(posedge clk) begin
    hold_pkt_q <= hold_pkt_d;
  end

  assign bus.req_ready_ex    = ready;
  assign bus.iprf_wr_en_ro0  = wr_en_q;
  assign bus.iprf_wr_pkt_ro0 = wr_pkt_q;
  assign wb_busy             = (|hold_vld_q) | (|wr_en_q);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_pdst_chk
    for (genvar m = k + 1; m < NUM_PORTS; m++) begin : g_pair
      a_pdst_unique: assert property (@(posedge clk) disable iff (!reset)
        !(wr_en_q[k] && wr_en_q[m] && (wr_pkt_q[k].pdst == wr_pkt_q[m].pdst)));
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_chk
    a_pkt_stable: assert property (@(posedge clk) disable iff (!reset)
      (bus.req_valid_ex[i] && !ready[i]) |=> $stable(bus.req_pkt_ex[i]));
  end

endmodule
